mfp_line_draw_sequencer: RTL and testbench
==========================================

# mfp_line_draw_sequencer

Command scheduler for the memory-mapped line-drawing engine in the MIPSfpga system. It buffers line commands written by the AHB I/O decoder into a FIFO and drives the engine's coordinate, START and RESET inputs one command at a time. It waits for FINISH before issuing the next command, and recovers a hung engine with a timed RESET. It sits between the AHB GPIO decode logic in `mfp_ahb_withloader` and the `IO_LINE_DRAWING_*` pins.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 1048576: maximum WAIT cycles before recovery; at least 2.
- `RST_CYCLES`, 4: width of the recovery RESET pulse; at least 1.
- `HCLK` in 1: sole clock, rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `CMD_VALID` in 1: command offered this cycle.
- `CMD_READY` out 1: FIFO can accept.
- `CMD_X0`, `CMD_X1`, `CMD_Y0`, `CMD_Y1` in 13 each: command coordinates.
- `STAT_CLEAR` in 1: clears the sticky status bits.
- `IO_LINE_DRAWING_FINISH` in 1: engine done flag.
- `IO_LINE_DRAWING_X0`, `IO_LINE_DRAWING_X1`, `IO_LINE_DRAWING_Y0`, `IO_LINE_DRAWING_Y1` out 13 each: coordinates presented to the engine.
- `IO_LINE_DRAWING_START` out 1: one-cycle start pulse.
- `IO_LINE_DRAWING_RESET` out 1: engine reset pulse.
- `STAT_LEVEL` out $clog2(DEPTH)+1: FIFO occupancy.
- `STAT_BUSY` out 1: FSM not IDLE.
- `STAT_TIMEOUT` out 1: sticky; a recovery has occurred.
- `STAT_OVERFLOW` out 1: sticky; a command was offered while the FIFO was full.

## Operation
- Push: `CMD_VALID & CMD_READY` writes `{X0,X1,Y0,Y1}`. `CMD_READY = (STAT_LEVEL < DEPTH)`, combinational from the level register.
- `CMD_VALID & ~CMD_READY` drops the command and sets `STAT_OVERFLOW`.
- Pop happens only in IDLE when the FIFO is non-empty.
- A push and a pop in the same cycle leave the level unchanged.
- A push into an empty FIFO is not visible to the pop until the next cycle.
- FSM states:
  - IDLE: if level > 0, pop and register the head entry onto the `IO_LINE_DRAWING_X/Y` outputs, then go to SETUP.
  - SETUP: coordinates are held stable for one cycle. Go to START.
  - START: `IO_LINE_DRAWING_START` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: increment the counter. A rising edge of FINISH (FINISH = 1 and previous-cycle FINISH = 0) goes to IDLE. If the counter reaches `TIMEOUT_CYCLES - 1` with no edge, go to RECOVER.
  - RECOVER: `IO_LINE_DRAWING_RESET` = 1 for `RST_CYCLES` cycles, set `STAT_TIMEOUT`, drop the command, then go to IDLE.
- A FINISH edge in the same cycle the timeout is reached counts as completion; timeout is not flagged.
- FINISH edges outside WAIT are ignored.
- The coordinate outputs hold their last popped value until the next pop, including through RECOVER.
- Sticky bits: `STAT_CLEAR` clears them. If a set event and `STAT_CLEAR` occur in the same cycle, the set wins.
- The timeout counter saturates and never wraps. Its width is $clog2(TIMEOUT_CYCLES).
- Arithmetic: the level counter is $clog2(DEPTH)+1 bits. FIFO pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.

## Timing
- Reset values:
  - All `IO_LINE_DRAWING_*` outputs = 0.
  - `STAT_LEVEL` = 0, `STAT_BUSY` = 0, both sticky bits = 0.
  - `CMD_READY` = 1.
  - FSM in IDLE, FINISH history = 0.
- Asserting `HRESETn` low mid-command aborts immediately: the FIFO is emptied, START and RESET drop the same instant, and no partial state survives.
- Latency: a command accepted at edge N, with the FIFO empty and the FSM in IDLE, is popped at edge N+1. START is high during cycle N+3 (edge N+3 to N+4).
- Minimum per-command occupancy is 4 cycles (IDLE, SETUP, START, WAIT plus the FINISH edge), so back-to-back commands issue START at best every 4 cycles.
- All outputs are registered except `CMD_READY`.

## Structure
- Shared package `mfp_line_draw_pkg`:
  - `LD_COORD_W` = 13.
  - Command struct/concatenation width 52.
  - FSM state encoding: IDLE, SETUP, START, WAIT, RECOVER.
- Sub-module `mfp_line_cmd_fifo`: a synchronous DEPTH×52 FIFO with push/pop/level. The FSM, timeout counter and status registers live in the top module.

## Test plan
- Single command (3,4,100,200) into an idle block → coordinates = (3,4,100,200) at edge N+1; one START pulse in cycle N+3; `STAT_BUSY` stays 1 until the cycle after the FINISH rising edge.
- Push 9 commands back-to-back with DEPTH=8 and FINISH held low → `CMD_READY` goes 0 once the level reaches 8; the dropped 9th command sets `STAT_OVERFLOW`; `STAT_LEVEL` never exceeds 8.
- Engine never finishes with TIMEOUT_CYCLES=16 → RESET high for exactly 4 cycles starting 16 WAIT cycles after START; `STAT_TIMEOUT` = 1; the next queued command then starts normally.
- FINISH held high across START with no new rising edge → no completion; timeout path taken. A FINISH edge coinciding with the final timeout cycle → completion, `STAT_TIMEOUT` stays 0.
- Assert `HRESETn` low during WAIT with 3 commands queued → all outputs 0 immediately, `STAT_LEVEL` = 0, and no START after reset is released.
- `STAT_CLEAR` in the same cycle as a new overflow → `STAT_OVERFLOW` remains 1; a later `STAT_CLEAR` alone → 0.

Source files
------------

// File: rtl/mfp_line_draw_pkg.sv
// Shared types for the line-drawing command sequencer: coordinate width,
// packed command record and FSM state encoding.
package mfp_line_draw_pkg;

  localparam int LD_COORD_W = 13;
  localparam int LD_CMD_W   = 4 * LD_COORD_W;

  typedef struct packed {
    logic [LD_COORD_W-1:0] x0;
    logic [LD_COORD_W-1:0] x1;
    logic [LD_COORD_W-1:0] y0;
    logic [LD_COORD_W-1:0] y1;
  } ld_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RECOVER = 3'd4
  } ld_state_e;

endpackage

// File: rtl/mfp_line_cmd_fifo.sv
// Synchronous DEPTH x 52-bit command FIFO with registered occupancy level.
// Head entry is read combinationally; full pushes and empty pops are ignored.
module mfp_line_cmd_fifo
  import mfp_line_draw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  ld_cmd_t                  data_i,
  input  logic                     pop_i,
  output ld_cmd_t                  data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  ld_cmd_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           push_ok, pop_ok;

  assign push_ok = push_i && (level_q != LVL_FULL);
  assign pop_ok  = pop_i && (level_q != '0);

  // Pointers are AW bits wide and wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/mfp_line_draw_sequencer.sv
// Buffers line commands and issues them one at a time to the line-drawing
// engine, waiting for FINISH and recovering a hung engine with a timed RESET.
module mfp_line_draw_sequencer
  import mfp_line_draw_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int RST_CYCLES     = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [LD_COORD_W-1:0]  CMD_X0,
  input  logic [LD_COORD_W-1:0]  CMD_X1,
  input  logic [LD_COORD_W-1:0]  CMD_Y0,
  input  logic [LD_COORD_W-1:0]  CMD_Y1,
  input  logic                   STAT_CLEAR,
  input  logic                   IO_LINE_DRAWING_FINISH,
  output logic [LD_COORD_W-1:0]  IO_LINE_DRAWING_X0,
  output logic [LD_COORD_W-1:0]  IO_LINE_DRAWING_X1,
  output logic [LD_COORD_W-1:0]  IO_LINE_DRAWING_Y0,
  output logic [LD_COORD_W-1:0]  IO_LINE_DRAWING_Y1,
  output logic                   IO_LINE_DRAWING_START,
  output logic                   IO_LINE_DRAWING_RESET,
  output logic [$clog2(DEPTH):0] STAT_LEVEL,
  output logic                   STAT_BUSY,
  output logic                   STAT_TIMEOUT,
  output logic                   STAT_OVERFLOW
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RC_LAST  = RW'(RST_CYCLES - 1);

  ld_state_e      state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  ld_cmd_t        coord_q, coord_d;
  logic           fin_prev_q;
  logic           start_q, start_d;
  logic           reset_q, reset_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;
  logic           ovf_q, ovf_d;

  logic [LW-1:0]  level;
  ld_cmd_t        head;
  ld_cmd_t        cmd_in;
  logic           push, pop, fin_rise, tmo_set, ovf_set;

  assign CMD_READY = (level < LVL_FULL);
  assign push      = CMD_VALID & CMD_READY;
  assign ovf_set   = CMD_VALID & ~CMD_READY;
  assign cmd_in    = '{x0: CMD_X0, x1: CMD_X1, y0: CMD_Y0, y1: CMD_Y1};
  assign fin_rise  = IO_LINE_DRAWING_FINISH & ~fin_prev_q;

  mfp_line_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .push_i  (push),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    coord_d = coord_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          coord_d = head;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_START;
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rcnt_d = '0;
        // A FINISH edge on the last timeout cycle still counts as completion.
        if (fin_rise) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RECOVER;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_RECOVER: begin
        if (rcnt_q == RC_LAST) state_d = ST_IDLE;
        else                   rcnt_d  = rcnt_q + RW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    start_d = (state_q == ST_START);
    reset_d = (state_d == ST_RECOVER);
    busy_d  = (state_d != ST_IDLE);
    tmo_set = (state_q == ST_WAIT) && (state_d == ST_RECOVER);
    // Set events take priority over a simultaneous clear.
    tmo_d   = tmo_set | (tmo_q & ~STAT_CLEAR);
    ovf_d   = ovf_set | (ovf_q & ~STAT_CLEAR);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      coord_q    <= '0;
      fin_prev_q <= 1'b0;
      start_q    <= 1'b0;
      reset_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      coord_q    <= coord_d;
      fin_prev_q <= IO_LINE_DRAWING_FINISH;
      start_q    <= start_d;
      reset_q    <= reset_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
    end
  end

  assign IO_LINE_DRAWING_X0    = coord_q.x0;
  assign IO_LINE_DRAWING_X1    = coord_q.x1;
  assign IO_LINE_DRAWING_Y0    = coord_q.y0;
  assign IO_LINE_DRAWING_Y1    = coord_q.y1;
  assign IO_LINE_DRAWING_START = start_q;
  assign IO_LINE_DRAWING_RESET = reset_q;
  assign STAT_LEVEL            = level;
  assign STAT_BUSY             = busy_q;
  assign STAT_TIMEOUT          = tmo_q;
  assign STAT_OVERFLOW         = ovf_q;

endmodule

// File: tb/tb_mfp_line_draw_sequencer.sv
// Directed bench for mfp_line_draw_sequencer: table-driven single commands
// plus hand-written overflow, timeout, FINISH-edge and reset sequences.
module tb_mfp_line_draw_sequencer;

  localparam int DEPTH = 8;
  localparam int TO    = 16;
  localparam int RC    = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [12:0] CMD_X0, CMD_X1, CMD_Y0, CMD_Y1;
  logic        STAT_CLEAR;
  logic        FIN;
  logic [12:0] OX0, OX1, OY0, OY1;
  logic        OSTART, ORESET;
  logic [3:0]  STAT_LEVEL;
  logic        STAT_BUSY, STAT_TIMEOUT, STAT_OVERFLOW;

  int n_chk  = 0;
  int n_fail = 0;

  mfp_line_draw_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .RST_CYCLES     (RC)
  ) dut (
    .HCLK                   (HCLK),
    .HRESETn                (HRESETn),
    .CMD_VALID              (CMD_VALID),
    .CMD_READY              (CMD_READY),
    .CMD_X0                 (CMD_X0),
    .CMD_X1                 (CMD_X1),
    .CMD_Y0                 (CMD_Y0),
    .CMD_Y1                 (CMD_Y1),
    .STAT_CLEAR             (STAT_CLEAR),
    .IO_LINE_DRAWING_FINISH (FIN),
    .IO_LINE_DRAWING_X0     (OX0),
    .IO_LINE_DRAWING_X1     (OX1),
    .IO_LINE_DRAWING_Y0     (OY0),
    .IO_LINE_DRAWING_Y1     (OY1),
    .IO_LINE_DRAWING_START  (OSTART),
    .IO_LINE_DRAWING_RESET  (ORESET),
    .STAT_LEVEL             (STAT_LEVEL),
    .STAT_BUSY              (STAT_BUSY),
    .STAT_TIMEOUT           (STAT_TIMEOUT),
    .STAT_OVERFLOW          (STAT_OVERFLOW)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [12:0] x0, x1, y0, y1;
    logic [12:0] ex0, ex1, ey0, ey1;
    int          exp_lat;
    int          fin_delay;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
  endtask

  task automatic set_cmd(input logic [12:0] a, input logic [12:0] b,
                         input logic [12:0] c, input logic [12:0] d);
    CMD_X0 = a; CMD_X1 = b; CMD_Y0 = c; CMD_Y1 = d;
  endtask

  task automatic wait_start(output int lat, input int maxc);
    lat = 0;
    while (OSTART !== 1'b1 && lat < maxc) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_reset(output int lat, input int maxc);
    lat = 0;
    while (ORESET !== 1'b1 && lat < maxc) begin
      step();
      lat++;
    end
  endtask

  task automatic chk_coords(input string nm, input logic [12:0] a, input logic [12:0] b,
                            input logic [12:0] c, input logic [12:0] d);
    chk({nm, "_x0"}, OX0, a);
    chk({nm, "_x1"}, OX1, b);
    chk({nm, "_y0"}, OY0, c);
    chk({nm, "_y1"}, OY1, d);
  endtask

  initial begin
    int lat, w, starts;

    vecs[0] = '{13'd3,    13'd4,    13'd100,  13'd200,  13'd3,    13'd4,    13'd100,  13'd200,  3, 0};
    vecs[1] = '{13'd0,    13'd0,    13'd0,    13'd0,    13'd0,    13'd0,    13'd0,    13'd0,    3, 2};
    vecs[2] = '{13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd8191, 3, 5};
    vecs[3] = '{13'h1555, 13'h0AAA, 13'd1,    13'd8190, 13'h1555, 13'h0AAA, 13'd1,    13'd8190, 3, 10};

    HRESETn = 1'b0; CMD_VALID = 1'b0; STAT_CLEAR = 1'b0; FIN = 1'b0;
    set_cmd(13'd0, 13'd0, 13'd0, 13'd0);
    step(); step();

    chk("rst_start", OSTART, 1'b0);
    chk("rst_reset", ORESET, 1'b0);
    chk_coords("rst", 13'd0, 13'd0, 13'd0, 13'd0);
    chk("rst_level", STAT_LEVEL, 4'd0);
    chk("rst_busy", STAT_BUSY, 1'b0);
    chk("rst_tmo", STAT_TIMEOUT, 1'b0);
    chk("rst_ovf", STAT_OVERFLOW, 1'b0);
    chk("rst_ready", CMD_READY, 1'b1);
    HRESETn = 1'b1;
    step();

    // Single commands into an idle block.
    for (int i = 0; i < 4; i++) begin
      set_cmd(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      CMD_VALID = 1'b1;
      step();
      chk("vec_level_after_push", STAT_LEVEL, 4'd1);
      CMD_VALID = 1'b0;
      step();
      chk_coords("vec_coord", vecs[i].ex0, vecs[i].ex1, vecs[i].ey0, vecs[i].ey1);
      chk("vec_busy", STAT_BUSY, 1'b1);
      chk("vec_level_after_pop", STAT_LEVEL, 4'd0);
      wait_start(lat, 10);
      chk("vec_start_latency", lat + 1, vecs[i].exp_lat);
      step();
      chk("vec_start_one_cycle", OSTART, 1'b0);
      repeat (vecs[i].fin_delay) step();
      chk("vec_busy_before_finish", STAT_BUSY, 1'b1);
      FIN = 1'b1;
      step();
      chk("vec_busy_after_finish", STAT_BUSY, 1'b0);
      chk("vec_no_timeout", STAT_TIMEOUT, 1'b0);
      FIN = 1'b0;
      step();
    end

    // Hold the engine busy, then overfill the FIFO while it waits.
    set_cmd(13'd7, 13'd8, 13'd9, 13'd10);
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
    wait_start(lat, 10);
    chk("c0_start_latency", lat, 3);
    for (int k = 0; k < 9; k++) begin
      chk("ovf_ready_before_push", CMD_READY, (k < 8));
      set_cmd(13'(k + 1), 13'(13'h100 + k + 1), 13'(13'h1000 + k + 1), 13'(13'h1FF0 + k));
      CMD_VALID = 1'b1;
      step();
      chk("ovf_level", STAT_LEVEL, (k < 8) ? k + 1 : 8);
      chk("ovf_flag", STAT_OVERFLOW, (k == 8));
    end
    CMD_VALID = 1'b0;
    STAT_CLEAR = 1'b1;
    step();
    chk("ovf_clear_alone", STAT_OVERFLOW, 1'b0);
    CMD_VALID = 1'b1;
    step();
    chk("ovf_set_wins_over_clear", STAT_OVERFLOW, 1'b1);
    CMD_VALID = 1'b0;
    step();
    chk("ovf_clear_later", STAT_OVERFLOW, 1'b0);
    STAT_CLEAR = 1'b0;
    chk("c0_still_busy", STAT_BUSY, 1'b1);

    // 12 cycles have passed since START; RESET must appear 16 after it.
    wait_reset(w, 30);
    chk("tmo_reset_delay", 12 + w, 16);
    w = 0;
    while (ORESET === 1'b1 && w < 20) begin
      if (w == 0) chk_coords("tmo_coord_hold", 13'd7, 13'd8, 13'd9, 13'd10);
      step();
      w++;
    end
    chk("tmo_reset_width", w, RC);
    chk("tmo_flag", STAT_TIMEOUT, 1'b1);
    STAT_CLEAR = 1'b1;
    FIN = 1'b1;
    step();
    STAT_CLEAR = 1'b0;
    chk("tmo_cleared", STAT_TIMEOUT, 1'b0);

    // Next queued command starts; FINISH held high gives no rising edge.
    wait_start(lat, 20);
    chk("c1_started", OSTART, 1'b1);
    chk_coords("c1_coord", 13'd1, 13'h101, 13'h1001, 13'h1FF0);
    wait_reset(w, 30);
    chk("c1_held_finish_reset_delay", w, 16);
    chk("c1_held_finish_tmo", STAT_TIMEOUT, 1'b1);
    w = 0;
    while (ORESET === 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk("c1_reset_width", w, RC);
    FIN = 1'b0;
    STAT_CLEAR = 1'b1;
    step();
    STAT_CLEAR = 1'b0;

    // FINISH edge exactly on the final timeout cycle counts as completion.
    wait_start(lat, 20);
    chk("c2_started", OSTART, 1'b1);
    chk_coords("c2_coord", 13'd2, 13'h102, 13'h1002, 13'h1FF1);
    repeat (15) step();
    FIN = 1'b1;
    step();
    chk("edge_timeout_busy", STAT_BUSY, 1'b0);
    chk("edge_timeout_reset", ORESET, 1'b0);
    chk("edge_timeout_flag", STAT_TIMEOUT, 1'b0);
    FIN = 1'b0;
    step();

    // Clean reset, then abort a running command with three queued.
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      set_cmd(13'(20 + k), 13'(30 + k), 13'(40 + k), 13'(50 + k));
      CMD_VALID = 1'b1;
      step();
    end
    CMD_VALID = 1'b0;
    wait_start(lat, 10);
    chk("abort_started", OSTART, 1'b1);
    chk("abort_level_queued", STAT_LEVEL, 4'd3);
    #1 HRESETn = 1'b0;
    #1;
    chk("abort_start", OSTART, 1'b0);
    chk("abort_reset", ORESET, 1'b0);
    chk_coords("abort", 13'd0, 13'd0, 13'd0, 13'd0);
    chk("abort_level", STAT_LEVEL, 4'd0);
    chk("abort_busy", STAT_BUSY, 1'b0);
    chk("abort_ready", CMD_READY, 1'b1);
    step();
    HRESETn = 1'b1;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (OSTART === 1'b1) starts++;
    end
    chk("abort_no_start_after_release", starts, 0);
    chk("abort_level_after_release", STAT_LEVEL, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
